bw_io_ddr_strobe_chk: RTL and testbench

- Receive-side companion to the DDR pad test strobe driver: in test mode it samples the strobe looped back from the DDR pad and counts rising edges over a programmable window of core-clock cycles.
- It then compares the count against an expected value and reports pass/fail.
- Sits in the DDR IO test logic next to each strobe pad and is used for manufacturing loopback of the DQS path.

---
 rtl/bw_io_ddr_strobe_chk.sv | 154 +++++++++++++++
 tb/tb_bw_io_ddr_strobe_chk.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bw_io_ddr_strobe_chk.sv
// DDR strobe loopback checker: counts synchronized rising edges of the
// returned strobe over a programmed window and compares against an expected count.
// Latency: done is win_len + 4 cycles after the accepted start; start is ignored while busy.
//
// Ports:
//   clk, arst              core clock, asynchronous active-high reset
//   testmode_l             active-low run enable; raising it aborts a measurement
//   start                  one-cycle measurement request (accepted only in IDLE)
//   strobe_in              looped-back strobe, asynchronous to clk
//   win_len, exp_cnt       window length and expected edge count, latched on accept
//   busy, done, pass       status: busy SETTLE..DONE, one-cycle done, held result
//   edge_cnt               live / final saturating rising-edge count
module bw_io_ddr_strobe_chk #(
  parameter int CW   = 8,
  parameter int WW   = 8,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          testmode_l,
  input  logic          start,
  input  logic          strobe_in,
  input  logic [WW-1:0] win_len,
  input  logic [CW-1:0] exp_cnt,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COUNT  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Settle time covers the synchronizer plus history flop, so no edge that
  // predates the accept can leak into the window as a stale rise pulse.
  localparam logic [2:0]    SETTLE_LD = 3'(SYNC + 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  state_t          state_q, state_d;
  logic [SYNC-1:0] sync_q, sync_d;
  logic            hist_q, hist_d;
  logic [2:0]      settle_q, settle_d;
  logic [WW-1:0]   win_cnt_q, win_cnt_d;
  logic [CW-1:0]   exp_q, exp_d;
  logic [CW-1:0]   edge_cnt_q, edge_cnt_d;
  logic            pass_q, pass_d;

  logic            rise;
  logic [CW-1:0]   cnt_nxt;

  // Synchronizer and history run every cycle regardless of FSM state.
  always_comb begin
    sync_d = {sync_q[SYNC-2:0], strobe_in};
    hist_d = sync_q[SYNC-1];
  end

  assign rise    = sync_q[SYNC-1] & ~hist_q;
  // Saturating increment: a runaway strobe pins the count at all-ones.
  assign cnt_nxt = (rise && (edge_cnt_q != CNT_MAX)) ? edge_cnt_q + CW'(1) : edge_cnt_q;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    win_cnt_d  = win_cnt_q;
    exp_d      = exp_q;
    edge_cnt_d = edge_cnt_q;
    pass_d     = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start && !testmode_l) begin
          win_cnt_d  = win_len;
          exp_d      = exp_cnt;
          edge_cnt_d = '0;
          pass_d     = 1'b0;
          settle_d   = SETTLE_LD;
          state_d    = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (testmode_l) begin
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - 3'd1;
          if (settle_q == 3'd1) begin
            // win_cnt_q still holds the latched window length here.
            if (win_cnt_q == '0) begin
              pass_d  = (edge_cnt_q == exp_q);
              state_d = S_DONE;
            end else begin
              state_d = S_COUNT;
            end
          end
        end
      end

      S_COUNT: begin
        if (testmode_l) begin
          // Abort: partial count is kept, pass stays cleared from accept.
          state_d = S_IDLE;
        end else begin
          edge_cnt_d = cnt_nxt;
          win_cnt_d  = win_cnt_q - WW'(1);
          if (win_cnt_q == WW'(1)) begin
            // Result registered on entry so it appears alongside done.
            pass_d  = (cnt_nxt == exp_q);
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      hist_q     <= 1'b0;
      settle_q   <= '0;
      win_cnt_q  <= '0;
      exp_q      <= '0;
      edge_cnt_q <= '0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      settle_q   <= settle_d;
      win_cnt_q  <= win_cnt_d;
      exp_q      <= exp_d;
      edge_cnt_q <= edge_cnt_d;
      pass_q     <= pass_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign pass     = pass_q;
  assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_bw_io_ddr_strobe_chk.sv
// Directed bench for bw_io_ddr_strobe_chk: default build plus a CW=4 build
// sharing the same stimulus, used for the saturation case.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
module tb_bw_io_ddr_strobe_chk;

  logic       clk;
  logic       arst;
  logic       testmode_l;
  logic       start;
  logic       strobe_in;
  logic [7:0] win_len;
  logic [7:0] exp_cnt;
  logic [3:0] exp_cnt4;
  logic       busy, done, pass;
  logic [7:0] edge_cnt;
  logic       busy4, done4, pass4;
  logic [3:0] edge_cnt4;

  int checks = 0;
  int errors = 0;

  // Per-run observations
  int         busy_cycles, busy4_cycles, done_pulses, done4_pulses, done_j;
  logic       pass_at_done, pass4_at_done;
  logic [7:0] cnt_at_done;
  logic [3:0] cnt4_at_done;
  logic       final_busy, final_pass;
  logic [7:0] final_cnt;
  logic       pre_rst_busy;
  logic [7:0] pre_rst_cnt;
  logic       rst_busy, rst_done, rst_pass;
  logic [7:0] rst_cnt;

  bw_io_ddr_strobe_chk #(.CW(8), .WW(8), .SYNC(2)) dut (
    .clk(clk), .arst(arst), .testmode_l(testmode_l), .start(start),
    .strobe_in(strobe_in), .win_len(win_len), .exp_cnt(exp_cnt),
    .busy(busy), .done(done), .pass(pass), .edge_cnt(edge_cnt)
  );

  bw_io_ddr_strobe_chk #(.CW(4), .WW(8), .SYNC(2)) dut4 (
    .clk(clk), .arst(arst), .testmode_l(testmode_l), .start(start),
    .strobe_in(strobe_in), .win_len(win_len), .exp_cnt(exp_cnt4),
    .busy(busy4), .done(done4), .pass(pass4), .edge_cnt(edge_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs ncyc cycles; j=0 is the cycle carrying the start pulse.
  // Strobe: h==0 -> constant o[0]; else ((j+o)/h)%2 (period 2h).
  // abort_at: testmode_l=1 from that cycle on; bstart_at: extra start;
  // rst_at: pulse arst inside that cycle. Negative disables.
  task automatic run_meas(input int win, input int expv, input int exp4v,
                          input int h, input int o, input int abort_at,
                          input int bstart_at, input int rst_at, input int ncyc);
    busy_cycles = 0; busy4_cycles = 0; done_pulses = 0; done4_pulses = 0; done_j = -1;
    pass_at_done = 1'b0; pass4_at_done = 1'b0; cnt_at_done = '0; cnt4_at_done = '0;
    for (int j = 0; j < ncyc; j++) begin
      @(posedge clk);
      #1;
      start = (j == 0) || (j == bstart_at);
      if (j == 0) begin
        win_len = 8'(win); exp_cnt = 8'(expv); exp_cnt4 = 4'(exp4v);
      end else begin
        win_len = 8'd2; exp_cnt = 8'hA5; exp_cnt4 = 4'h3;
      end
      testmode_l = (abort_at >= 0) && (j >= abort_at);
      strobe_in  = (h == 0) ? o[0] : ((((j + o) / h) % 2) == 1);
      if (j == rst_at) begin
        pre_rst_busy = busy;
        pre_rst_cnt  = edge_cnt;
        arst = 1'b1;
        #1;
        rst_busy = busy; rst_done = done; rst_pass = pass; rst_cnt = edge_cnt;
        arst = 1'b0;
      end
      @(negedge clk);
      if (busy)  busy_cycles++;
      if (busy4) busy4_cycles++;
      if (done4) begin
        done4_pulses++;
        pass4_at_done = pass4;
        cnt4_at_done  = edge_cnt4;
      end
      if (done) begin
        done_pulses++;
        done_j       = j;
        pass_at_done = pass;
        cnt_at_done  = edge_cnt;
      end
      final_busy = busy; final_pass = pass; final_cnt = edge_cnt;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass); end
    checks++; if (edge_cnt !== 8'd0) begin errors++; $display("FAIL reset_edge_cnt: got %0d expected 0", edge_cnt); end
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_basic_pass;
    run_meas(16, 4, 4, 2, 0, -1, -1, -1, 24);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (done_j !== 20) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 20", done_j); end
    checks++; if (busy_cycles !== 20) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 20", busy_cycles); end
    checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL basic_pass: got %b expected 1", pass_at_done); end
    checks++; if (cnt_at_done !== 8'd4) begin errors++; $display("FAIL basic_edge_cnt: got %0d expected 4", cnt_at_done); end
    checks++; if (final_pass !== 1'b1) begin errors++; $display("FAIL basic_pass_held: got %b expected 1", final_pass); end
    checks++; if (final_cnt !== 8'd4) begin errors++; $display("FAIL basic_cnt_held: got %0d expected 4", final_cnt); end
    checks++; if (final_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", final_busy); end
  endtask

  task automatic test_fail_count;
    run_meas(16, 5, 5, 2, 0, -1, -1, -1, 24);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL fail_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (pass_at_done !== 1'b0) begin errors++; $display("FAIL fail_pass: got %b expected 0", pass_at_done); end
    checks++; if (cnt_at_done !== 8'd4) begin errors++; $display("FAIL fail_edge_cnt: got %0d expected 4", cnt_at_done); end
  endtask

  task automatic test_static_strobe;
    run_meas(16, 0, 0, 0, 1, -1, -1, -1, 24);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL static_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL static_pass: got %b expected 1", pass_at_done); end
    checks++; if (cnt_at_done !== 8'd0) begin errors++; $display("FAIL static_edge_cnt: got %0d expected 0", cnt_at_done); end
  endtask

  task automatic test_saturation;
    run_meas(255, 127, 15, 1, 0, -1, -1, -1, 262);
    checks++; if (done_j !== 259) begin errors++; $display("FAIL sat_done_cycle: got %0d expected 259", done_j); end
    checks++; if (cnt_at_done !== 8'd127) begin errors++; $display("FAIL sat_cw8_cnt: got %0d expected 127", cnt_at_done); end
    checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL sat_cw8_pass: got %b expected 1", pass_at_done); end
    checks++; if (done4_pulses !== 1) begin errors++; $display("FAIL sat_cw4_done_pulses: got %0d expected 1", done4_pulses); end
    checks++; if (busy4_cycles !== 259) begin errors++; $display("FAIL sat_cw4_busy_cycles: got %0d expected 259", busy4_cycles); end
    checks++; if (cnt4_at_done !== 4'd15) begin errors++; $display("FAIL sat_cw4_cnt: got %0d expected 15", cnt4_at_done); end
    checks++; if (pass4_at_done !== 1'b1) begin errors++; $display("FAIL sat_cw4_pass: got %b expected 1", pass4_at_done); end
  endtask

  task automatic test_zero_window;
    run_meas(0, 0, 0, 2, 0, -1, -1, -1, 8);
    checks++; if (done_j !== 4) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 4", done_j); end
    checks++; if (busy_cycles !== 4) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 4", busy_cycles); end
    checks++; if (cnt_at_done !== 8'd0) begin errors++; $display("FAIL zero_edge_cnt: got %0d expected 0", cnt_at_done); end
    checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL zero_pass_exp0: got %b expected 1", pass_at_done); end
    run_meas(0, 3, 3, 2, 0, -1, -1, -1, 8);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL zero_exp3_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (pass_at_done !== 1'b0) begin errors++; $display("FAIL zero_pass_exp3: got %b expected 0", pass_at_done); end
  endtask

  task automatic test_start_busy;
    run_meas(16, 4, 4, 2, 0, -1, 5, -1, 24);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL busy_start_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (done_j !== 20) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 20", done_j); end
    checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL busy_start_pass: got %b expected 1", pass_at_done); end
    checks++; if (cnt_at_done !== 8'd4) begin errors++; $display("FAIL busy_start_cnt: got %0d expected 4", cnt_at_done); end
    run_meas(16, 4, 4, 2, 0, -1, 20, -1, 26);
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL done_start_done_pulses: got %0d expected 1", done_pulses); end
    checks++; if (busy_cycles !== 20) begin errors++; $display("FAIL done_start_busy_cycles: got %0d expected 20", busy_cycles); end
    checks++; if (final_busy !== 1'b0) begin errors++; $display("FAIL done_start_busy_after: got %b expected 0", final_busy); end
  endtask

  task automatic test_testmode_gate;
    // Previous run left pass=1, edge_cnt=4; an ignored start must not touch them.
    run_meas(16, 0, 0, 2, 0, 0, -1, -1, 6);
    checks++; if (busy_cycles !== 0) begin errors++; $display("FAIL gate_busy_cycles: got %0d expected 0", busy_cycles); end
    checks++; if (done_pulses !== 0) begin errors++; $display("FAIL gate_done_pulses: got %0d expected 0", done_pulses); end
    checks++; if (final_pass !== 1'b1) begin errors++; $display("FAIL gate_pass_kept: got %b expected 1", final_pass); end
    checks++; if (final_cnt !== 8'd4) begin errors++; $display("FAIL gate_cnt_kept: got %0d expected 4", final_cnt); end
  endtask

  task automatic test_abort;
    // Rise pulses land in cycles 5, 9, ...; abort requested in cycle 8 (COUNT cycle 5).
    run_meas(16, 1, 1, 2, 3, 8, -1, -1, 24);
    checks++; if (done_pulses !== 0) begin errors++; $display("FAIL abort_done_pulses: got %0d expected 0", done_pulses); end
    checks++; if (busy_cycles !== 8) begin errors++; $display("FAIL abort_busy_cycles: got %0d expected 8", busy_cycles); end
    checks++; if (final_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", final_busy); end
    checks++; if (final_pass !== 1'b0) begin errors++; $display("FAIL abort_pass: got %b expected 0", final_pass); end
    checks++; if (final_cnt !== 8'd1) begin errors++; $display("FAIL abort_partial_cnt: got %0d expected 1", final_cnt); end
  endtask

  task automatic test_reset_mid_count;
    run_meas(16, 4, 4, 2, 0, -1, -1, 12, 16);
    checks++; if (pre_rst_busy !== 1'b1) begin errors++; $display("FAIL rstmid_pre_busy: got %b expected 1", pre_rst_busy); end
    checks++; if (pre_rst_cnt !== 8'd2) begin errors++; $display("FAIL rstmid_pre_cnt: got %0d expected 2", pre_rst_cnt); end
    checks++; if (rst_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", rst_busy); end
    checks++; if (rst_done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", rst_done); end
    checks++; if (rst_pass !== 1'b0) begin errors++; $display("FAIL rstmid_pass: got %b expected 0", rst_pass); end
    checks++; if (rst_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", rst_cnt); end
    checks++; if (done_pulses !== 0) begin errors++; $display("FAIL rstmid_done_pulses: got %0d expected 0", done_pulses); end
    run_meas(16, 4, 4, 2, 0, -1, -1, -1, 24);
    checks++; if (done_j !== 20) begin errors++; $display("FAIL rstmid_rerun_cycle: got %0d expected 20", done_j); end
    checks++; if (pass_at_done !== 1'b1) begin errors++; $display("FAIL rstmid_rerun_pass: got %b expected 1", pass_at_done); end
    checks++; if (cnt_at_done !== 8'd4) begin errors++; $display("FAIL rstmid_rerun_cnt: got %0d expected 4", cnt_at_done); end
  endtask

  initial begin
    arst = 1'b1; testmode_l = 1'b0; start = 1'b0; strobe_in = 1'b0;
    win_len = '0; exp_cnt = '0; exp_cnt4 = '0;
    pre_rst_busy = 1'b0; pre_rst_cnt = '0;
    rst_busy = 1'b1; rst_done = 1'b1; rst_pass = 1'b1; rst_cnt = 8'hFF;
    test_reset();
    test_basic_pass();
    test_fail_count();
    test_static_strobe();
    test_saturation();
    test_zero_window();
    test_start_busy();
    test_testmode_gate();
    test_abort();
    test_reset_mid_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
